// File: rtl/wisc_pkg.sv
// Shared datapath constants and types for the 16-bit WISC core.
package wisc_pkg;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   localparam int IDX_W    = $clog2(NUM_REGS);

   typedef logic [IDX_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/register_file_reg_word.sv
// One architectural register: synchronous clear, load on wen.
module reg_word #(
   parameter int DATA_W = wisc_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (wen) begin
         r_q <= d;
      end
   end

   assign q = r_q;
endmodule

// File: rtl/register_file.sv
// Architectural register file: R0 hardwired to zero, two combinational
// read ports with same-cycle write bypass, one synchronous write port.
module register_file #(
   parameter int NUM_REGS = wisc_pkg::NUM_REGS,
   parameter int DATA_W   = wisc_pkg::DATA_W,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  src_reg1,
   input  logic [IDX_W-1:0]  src_reg2,
   input  logic [IDX_W-1:0]  dst_reg,
   input  logic              write_en,
   input  logic [DATA_W-1:0] dst_data,
   output logic [DATA_W-1:0] src_data1,
   output logic [DATA_W-1:0] src_data2
);
   import wisc_pkg::*;

   logic [DATA_W-1:0] w_q [NUM_REGS];
   logic              w_wr_live;

   // A write to R0 is a no-op, so it must neither store nor bypass.
   assign w_wr_live = write_en && (dst_reg != IDX_W'(ZERO_REG));

   assign w_q[0] = '0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
      logic w_wen;
      assign w_wen = w_wr_live && (dst_reg == IDX_W'(i));

      reg_word #(
         .DATA_W(DATA_W)
      ) u_reg (
         .clk (clk),
         .rst (rst),
         .wen (w_wen),
         .d   (dst_data),
         .q   (w_q[i])
      );
   end

   // Reset forces zero; otherwise bypass the in-flight write, else the stored value.
   always_comb begin
      src_data1 = w_q[src_reg1];
      if (w_wr_live && (dst_reg == src_reg1)) begin
         src_data1 = dst_data;
      end
      if (rst) begin
         src_data1 = '0;
      end
   end

   always_comb begin
      src_data2 = w_q[src_reg2];
      if (w_wr_live && (dst_reg == src_reg2)) begin
         src_data2 = dst_data;
      end
      if (rst) begin
         src_data2 = '0;
      end
   end
endmodule
